// File: rtl/duck_palette_pkg.sv
// duck_palette_pkg: shared types, reset palette and counter sizing for the duck palette block
package duck_palette_pkg;
  typedef logic [11:0] rgb12_t;
  typedef enum logic [1:0] {IDLE, FLASH_ON, FLASH_OFF} flash_state_t;
  localparam rgb12_t DEFAULT_PALETTE [0:15] = '{
    12'hAEA, 12'h00A, 12'hFFF, 12'hB0B, 12'hF76, 12'hAEA, 12'hAEA, 12'hAEA,
    12'hAEA, 12'hAEA, 12'hAEA, 12'hAEA, 12'hAEA, 12'hAEA, 12'hAEA, 12'hAEA
  };
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/duck_flash_fsm.sv
// duck_flash_fsm: hit-flash sequencer counting ON/OFF frame phases and blink pairs
module duck_flash_fsm
  import duck_palette_pkg::*;
#(
  parameter int FLASH_FRAMES = 4,
  parameter int FLASH_COUNT  = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_start_i,
  input  logic hit_pulse_i,
  output logic flash_on_o,
  output logic busy_o
);
  localparam int FW = cnt_w(FLASH_FRAMES);
  localparam int BW = cnt_w(FLASH_COUNT);
  localparam logic [FW-1:0] FMAX = FW'(FLASH_FRAMES - 1);
  localparam logic [BW-1:0] BMAX = BW'(FLASH_COUNT - 1);
  flash_state_t state_q, state_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    bcnt_d  = bcnt_q;
    if (hit_pulse_i) begin
      state_d = FLASH_ON;
      fcnt_d  = '0;
      bcnt_d  = '0;
    end else if (frame_start_i && state_q != IDLE) begin
      if (fcnt_q != FMAX) begin
        fcnt_d = fcnt_q + 1'b1;
      end else begin
        fcnt_d = '0;
        if (state_q == FLASH_ON) begin
          state_d = FLASH_OFF;
        end else if (bcnt_q == BMAX) begin
          state_d = IDLE;
        end else begin
          bcnt_d  = bcnt_q + 1'b1;
          state_d = FLASH_ON;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      fcnt_q  <= '0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      bcnt_q  <= bcnt_d;
    end
  end
  assign flash_on_o = (state_q == FLASH_ON);
  assign busy_o     = (state_q != IDLE);
endmodule

// File: rtl/duck_palette_ctrl.sv
// duck_palette_ctrl: 16-entry sprite palette with vblank-gated writes and hit-flash colour override
module duck_palette_ctrl
  import duck_palette_pkg::*;
#(
  parameter int          FLASH_FRAMES    = 4,
  parameter int          FLASH_COUNT     = 3,
  parameter logic [15:0] FLASH_MASK      = 16'h001A,
  parameter rgb12_t      FLASH_RGB       = 12'hFFF,
  parameter int          TRANSPARENT_IDX = 0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        pix_valid,
  input  logic [3:0]  pix_index,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        rgb_valid,
  output logic        transparent,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [3:0]  cfg_addr,
  input  logic [11:0] cfg_data,
  input  logic        vblank,
  input  logic        frame_start,
  input  logic        hit_pulse,
  output logic        busy
);
  localparam logic [3:0] TIDX = 4'(TRANSPARENT_IDX);
  rgb12_t pal_q [0:15];
  rgb12_t pal_d [0:15];
  rgb12_t rgb_q, rgb_d;
  logic   valid_q, transp_q, transp_d, flash_on;
  duck_flash_fsm #(
    .FLASH_FRAMES(FLASH_FRAMES),
    .FLASH_COUNT (FLASH_COUNT)
  ) u_fsm (
    .clk          (Clk),
    .rst          (Reset),
    .frame_start_i(frame_start),
    .hit_pulse_i  (hit_pulse),
    .flash_on_o   (flash_on),
    .busy_o       (busy)
  );
  assign cfg_ready = vblank & ~Reset;
  // Lookup reads pal_q, so a same-cycle write to that entry is seen only on the next lookup.
  always_comb begin
    pal_d = pal_q;
    if (cfg_valid && cfg_ready) pal_d[cfg_addr] = cfg_data;
    rgb_d = !pix_valid ? rgb_q
          : (flash_on && FLASH_MASK[pix_index] && pix_index != TIDX) ? FLASH_RGB
          : pal_q[pix_index];
    transp_d = pix_valid ? (pix_index == TIDX) : transp_q;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pal_q    <= DEFAULT_PALETTE;
      rgb_q    <= '0;
      valid_q  <= 1'b0;
      transp_q <= 1'b0;
    end else begin
      pal_q    <= pal_d;
      rgb_q    <= rgb_d;
      valid_q  <= pix_valid;
      transp_q <= transp_d;
    end
  end
  assign {red, green, blue} = rgb_q;
  assign rgb_valid          = valid_q;
  assign transparent        = transp_q;
endmodule

// File: tb/tb_duck_palette_ctrl.sv
// tb_duck_palette_ctrl: scoreboard bench for palette lookups, vblank writes and hit-flash sequencing
module tb_duck_palette_ctrl;
  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        pix_valid = 1'b0;
  logic [3:0]  pix_index = '0;
  logic [3:0]  red, green, blue;
  logic        rgb_valid, transparent, cfg_ready, busy;
  logic        cfg_valid = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [11:0] cfg_data = '0;
  logic        vblank = 1'b0;
  logic        frame_start = 1'b0;
  logic        hit_pulse = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  logic [12:0] sb_q [$];
  logic [11:0] mdl [16];
  logic [15:0] fmask = 16'h001A;

  duck_palette_ctrl dut (
    .Clk(Clk), .Reset(Reset), .pix_valid(pix_valid), .pix_index(pix_index),
    .red(red), .green(green), .blue(blue), .rgb_valid(rgb_valid),
    .transparent(transparent), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .vblank(vblank),
    .frame_start(frame_start), .hit_pulse(hit_pulse), .busy(busy)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load_defaults();
    mdl = '{12'hAEA, 12'h00A, 12'hFFF, 12'hB0B, 12'hF76, 12'hAEA, 12'hAEA, 12'hAEA,
            12'hAEA, 12'hAEA, 12'hAEA, 12'hAEA, 12'hAEA, 12'hAEA, 12'hAEA, 12'hAEA};
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic lookup(input int idx, input bit on);
    logic [11:0] e;
    e = (on && fmask[idx] && idx != 0) ? 12'hFFF : mdl[idx];
    sb_q.push_back({idx == 0, e});
    pix_valid = 1'b1;
    pix_index = 4'(idx);
    step();
    pix_valid = 1'b0;
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic pulse_hit();
    hit_pulse = 1'b1;
    step();
    hit_pulse = 1'b0;
  endtask

  task automatic flash_seq();
    for (int k = 0; k < 24; k++) begin
      for (int i = 0; i < 5; i++) lookup(i, (k % 8) < 4);
      check("busy_during_flash", 32'(busy), 32'd1);
      pulse_fs();
    end
    check("busy_after_flash", 32'(busy), 32'd0);
    for (int i = 0; i < 5; i++) lookup(i, 1'b0);
  endtask

  task automatic monitor();
    logic [12:0] e;
    forever begin
      @(negedge Clk);
      if (rgb_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_rgb_valid", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("rgb", 32'({red, green, blue}), 32'(e[11:0]));
          check("transparent", 32'(transparent), 32'(e[12]));
        end
      end
    end
  endtask

  initial begin
    load_defaults();
    fork
      monitor();
      begin
        vblank = 1'b1;
        step();
        step();
        check("reset_rgb", 32'({red, green, blue}), 32'd0);
        check("reset_rgb_valid", 32'(rgb_valid), 32'd0);
        check("reset_transparent", 32'(transparent), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_cfg_ready", 32'(cfg_ready), 32'd0);
        Reset = 1'b0;
        vblank = 1'b0;
        step();
        for (int i = 0; i < 16; i++) lookup(i, 1'b0);
        step();
        check("idle_rgb_valid", 32'(rgb_valid), 32'd0);
        // stalled write: request held while vblank is low
        cfg_valid = 1'b1;
        cfg_addr  = 4'd3;
        cfg_data  = 12'h123;
        #1;
        check("stall_cfg_ready", 32'(cfg_ready), 32'd0);
        lookup(3, 1'b0);
        lookup(3, 1'b0);
        vblank = 1'b1;
        #1;
        check("vblank_cfg_ready", 32'(cfg_ready), 32'd1);
        lookup(3, 1'b0);
        cfg_valid = 1'b0;
        mdl[3] = 12'h123;
        lookup(3, 1'b0);
        pulse_hit();
        flash_seq();
        pulse_hit();
        for (int k = 0; k < 5; k++) pulse_fs();
        lookup(1, 1'b0);
        check("busy_mid_off", 32'(busy), 32'd1);
        hit_pulse = 1'b1;
        frame_start = 1'b1;
        step();
        hit_pulse = 1'b0;
        frame_start = 1'b0;
        flash_seq();
        pulse_hit();
        lookup(1, 1'b1);
        step();
        Reset = 1'b1;
        step();
        check("midflash_reset_busy", 32'(busy), 32'd0);
        check("midflash_reset_rgb", 32'({red, green, blue}), 32'd0);
        check("midflash_reset_rgb_valid", 32'(rgb_valid), 32'd0);
        check("midflash_reset_transparent", 32'(transparent), 32'd0);
        Reset = 1'b0;
        load_defaults();
        lookup(3, 1'b0);
        lookup(1, 1'b0);
        lookup(4, 1'b0);
        pulse_hit();
        cfg_valid = 1'b1;
        cfg_addr  = 4'd4;
        cfg_data  = 12'hABC;
        lookup(4, 1'b1);
        cfg_valid = 1'b0;
        mdl[4] = 12'hABC;
        flash_seq();
        step();
        step();
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      end
    join_any
    disable fork;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
